// File: rtl/fpga_scan_loader.sv
// Scan-chain configuration loader for the fabric edge connection chain.
// Serialises host words into the chain and reads it back by rotating it.
module fpga_scan_loader #(
  parameter int CHAIN_LEN  = 256,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  scan_clk_i,
  input  logic                  reset_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_mode_i,
  input  logic [WORD_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_loaded_o,
  output logic                  conn_scan_en_o,
  output logic                  conn_scan_in_o,
  input  logic                  conn_scan_out_i
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] CHAIN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CHAIN_END  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(WORD_WIDTH - 1);
  localparam logic [WW-1:0] WCNT_ONE   = WW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_WAIT  = 3'd1,
    LD_SHIFT = 3'd2,
    RB_SHIFT = 3'd3,
    RB_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]         word_cnt_q, word_cnt_d;
  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [WORD_WIDTH-1:0] rd_q, rd_d;
  logic                  loaded_q, loaded_d;
  logic                  op_load_q, op_load_d;
  logic [WORD_WIDTH-1:0] rb_word_s;
  logic                  last_bit_s;
  logic                  last_word_bit_s;

  // Readback assembly fills from the MSB so the first chain-out bit ends in the LSB.
  if (WORD_WIDTH > 1) begin : g_rb_wide
    assign rb_word_s = {conn_scan_out_i, sr_q[WORD_WIDTH-1:1]};
  end else begin : g_rb_narrow
    assign rb_word_s = conn_scan_out_i;
  end

  assign last_bit_s      = (bit_cnt_q == CHAIN_LAST);
  assign last_word_bit_s = (word_cnt_q == WORD_LAST);
  assign rd_data_o       = rd_q;
  assign cfg_loaded_o    = loaded_q;

  // State and datapath registers.
  always_ff @(posedge scan_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sr_q       <= '0;
      rd_q       <= '0;
      loaded_q   <= 1'b0;
      op_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sr_q       <= sr_d;
      rd_q       <= rd_d;
      loaded_q   <= loaded_d;
      op_load_q  <= op_load_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    word_cnt_d     = word_cnt_q;
    sr_d           = sr_q;
    rd_d           = rd_q;
    loaded_d       = loaded_q;
    op_load_d      = op_load_q;
    cfg_ready_o    = 1'b0;
    rd_valid_o     = 1'b0;
    busy_o         = 1'b1;
    cfg_done_o     = 1'b0;
    conn_scan_en_o = 1'b0;
    conn_scan_in_o = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (cfg_start_i) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          op_load_d  = ~cfg_mode_i;
          if (cfg_mode_i) begin
            state_d = RB_SHIFT;
          end else begin
            loaded_d = 1'b0;
            state_d  = LD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LD_WAIT: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          sr_d       = cfg_data_i;
          word_cnt_d = '0;
          state_d    = LD_SHIFT;
        end else begin
          state_d = LD_WAIT;
        end
      end
      LD_SHIFT: begin
        conn_scan_en_o = 1'b1;
        conn_scan_in_o = sr_q[0];
        sr_d           = sr_q >> 1;
        bit_cnt_d      = bit_cnt_q + CNT_ONE;
        word_cnt_d     = word_cnt_q + WCNT_ONE;
        // Chain end wins over word end, so a partial last word's high bits never shift.
        if (last_bit_s) begin
          state_d = DONE;
        end else if (last_word_bit_s) begin
          state_d = LD_WAIT;
        end else begin
          state_d = LD_SHIFT;
        end
      end
      RB_SHIFT: begin
        conn_scan_en_o = 1'b1;
        conn_scan_in_o = conn_scan_out_i;
        sr_d           = rb_word_s;
        bit_cnt_d      = bit_cnt_q + CNT_ONE;
        word_cnt_d     = word_cnt_q + WCNT_ONE;
        if (last_bit_s || last_word_bit_s) begin
          rd_d    = rb_word_s >> (WORD_LAST - word_cnt_q);
          state_d = RB_HOLD;
        end else begin
          state_d = RB_SHIFT;
        end
      end
      RB_HOLD: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          word_cnt_d = '0;
          if (bit_cnt_q == CHAIN_END) begin
            state_d = DONE;
          end else begin
            state_d = RB_SHIFT;
          end
        end else begin
          state_d = RB_HOLD;
        end
      end
      DONE: begin
        cfg_done_o = 1'b1;
        state_d    = IDLE;
        if (op_load_q) begin
          loaded_d = 1'b1;
        end else begin
          loaded_d = loaded_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fpga_scan_loader.sv
// Bench for fpga_scan_loader: directed plus randomized load/readback against a
// bit-level chain image model.
module tb_fpga_scan_loader;
  localparam int CL = 12;
  localparam int W  = 8;
  localparam int NW = (CL + W - 1) / W;

  logic         clk = 1'b0;
  logic         reset, cfg_start, cfg_mode, cfg_valid, rd_ready;
  logic [W-1:0] cfg_data, rd_data;
  logic         cfg_ready, rd_valid, busy, cfg_done, cfg_loaded;
  logic         scan_en, scan_in, scan_out;
  logic [CL-1:0] chain;

  int checks = 0;
  int errors = 0;

  int en_cnt = 0, acc_cnt = 0, done_cnt = 0;
  bit sin_q[$];

  logic [W-1:0]  ld_words [NW];
  int            ld_stall [NW];
  logic [W-1:0]  got_rd   [NW];
  logic [CL-1:0] exp_chain;
  logic [CL-1:0] last_sin;
  bit            valid_hi;

  always #5 clk = ~clk;

  fpga_scan_loader #(.CHAIN_LEN(CL), .WORD_WIDTH(W)) dut (
    .scan_clk_i      (clk),
    .reset_i         (reset),
    .cfg_start_i     (cfg_start),
    .cfg_mode_i      (cfg_mode),
    .cfg_data_i      (cfg_data),
    .cfg_valid_i     (cfg_valid),
    .cfg_ready_o     (cfg_ready),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .busy_o          (busy),
    .cfg_done_o      (cfg_done),
    .cfg_loaded_o    (cfg_loaded),
    .conn_scan_en_o  (scan_en),
    .conn_scan_in_o  (scan_in),
    .conn_scan_out_i (scan_out)
  );

  // The fabric chain: head enters at the MSB, tail leaves from bit 0.
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_in, chain[CL-1:1]};
  end

  // Event counters sampled on the active edge.
  always @(posedge clk) begin
    if (scan_en) begin
      en_cnt <= en_cnt + 1;
      sin_q.push_back(scan_in);
    end
    if (cfg_ready && cfg_valid) acc_cnt <= acc_cnt + 1;
    if (cfg_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_ready"}, cfg_ready, 0);
    chk({t, "_rd_valid"}, rd_valid, 0);
    chk({t, "_rd_data"}, rd_data, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, cfg_done, 0);
    chk({t, "_loaded"}, cfg_loaded, 0);
    chk({t, "_scan_en"}, scan_en, 0);
    chk({t, "_scan_in"}, scan_in, 0);
  endtask

  // Chain image after a load: bit i of the stream (word i/W, bit i%W) sits at chain[i].
  task automatic build_model();
    for (int i = 0; i < CL; i++) exp_chain[i] = ld_words[i / W][i % W];
  endtask

  function automatic logic [W-1:0] exp_word(input int j);
    logic [W-1:0] w;
    w = '0;
    for (int b = 0; b < W; b++)
      if (j * W + b < CL) w[b] = exp_chain[j * W + b];
    return w;
  endfunction

  task automatic do_load(input int poke_at);
    int e0, a0, d0, q0, idx, cyc;
    int st [NW];
    bit seen_done, first_rdy;
    build_model();
    for (int k = 0; k < NW; k++) st[k] = ld_stall[k];
    e0 = en_cnt; a0 = acc_cnt; d0 = done_cnt; q0 = sin_q.size();
    idx = 0; cyc = 0; seen_done = 0; first_rdy = 1;
    cfg_start = 1'b1; cfg_mode = 1'b0;
    tick();
    cfg_start = 1'b0;
    while (!seen_done && cyc < 400) begin
      if (cfg_done) begin
        seen_done = 1;
      end else if (cfg_ready && idx < NW) begin
        if (first_rdy) begin
          chk("ld_loaded_cleared", cfg_loaded, 0);
          first_rdy = 0;
        end
        if (st[idx] > 0) begin
          chk("ld_stall_en", scan_en, 0);
          cfg_valid = 1'b0;
          st[idx]--;
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = ld_words[idx];
          idx++;
        end
      end else begin
        cfg_valid = valid_hi ? 1'b1 : 1'($urandom % 2);
        cfg_data  = W'($urandom);
      end
      if (cyc == poke_at) begin
        cfg_start = 1'b1; cfg_mode = 1'($urandom % 2);
      end else begin
        cfg_start = 1'b0;
      end
      cyc++;
      tick();
    end
    chk("ld_done_seen", seen_done, 1);
    cfg_valid = 1'b0; cfg_start = 1'b0;
    tick();
    chk("ld_loaded", cfg_loaded, 1);
    chk("ld_busy_after", busy, 0);
    tick(); tick(); tick();
    chk("ld_en_cycles", en_cnt - e0, CL);
    chk("ld_accepts", acc_cnt - a0, NW);
    chk("ld_done_pulses", done_cnt - d0, 1);
    last_sin = '0;
    for (int i = 0; i < CL && q0 + i < sin_q.size(); i++) last_sin[i] = sin_q[q0 + i];
    chk("ld_scan_in_seq", last_sin, exp_chain);
    chk("ld_chain_image", chain, exp_chain);
  endtask

  task automatic do_rb(input int hold0, input int poke_at);
    int e0, d0, idx, cyc, hold;
    bit seen_done, ld0;
    e0 = en_cnt; d0 = done_cnt; ld0 = cfg_loaded;
    idx = 0; cyc = 0; hold = hold0; seen_done = 0;
    cfg_start = 1'b1; cfg_mode = 1'b1;
    tick();
    cfg_start = 1'b0;
    while (!seen_done && cyc < 400) begin
      if (cfg_done) begin
        seen_done = 1;
      end else if (rd_valid) begin
        if (idx >= NW) begin
          chk("rb_extra_word", idx, NW - 1);
          rd_ready = 1'b1;
        end else if (hold > 0 && idx == 0) begin
          chk("rb_stall_data", rd_data, exp_word(0));
          chk("rb_stall_en", scan_en, 0);
          rd_ready = 1'b0;
          hold--;
        end else begin
          chk("rb_data", rd_data, exp_word(idx));
          got_rd[idx] = rd_data;
          rd_ready = 1'b1;
          idx++;
        end
      end else begin
        rd_ready = 1'($urandom % 2);
      end
      if (cyc == poke_at) begin
        cfg_start = 1'b1; cfg_mode = 1'($urandom % 2);
      end else begin
        cfg_start = 1'b0;
      end
      cyc++;
      tick();
    end
    chk("rb_done_seen", seen_done, 1);
    cfg_start = 1'b0; rd_ready = 1'b0;
    tick(); tick(); tick();
    chk("rb_words", idx, NW);
    chk("rb_en_cycles", en_cnt - e0, CL);
    chk("rb_done_pulses", done_cnt - d0, 1);
    chk("rb_chain_kept", chain, exp_chain);
    chk("rb_loaded_kept", cfg_loaded, ld0);
  endtask

  initial begin
    int e0, cyc;
    logic [CL-1:0] lit_seq;
    reset = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_valid = 1'b0;
    cfg_data = '0; rd_ready = 1'b0; valid_hi = 0;
    tick(); tick(); tick();
    chk_reset("rst");
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Directed load, valid always high.
    ld_words[0] = 8'hA5; ld_words[1] = 8'h3C;
    ld_stall[0] = 0; ld_stall[1] = 0;
    valid_hi = 1;
    do_load(-1);
    lit_seq = 12'b1100_1010_0101;
    chk("t1_literal_seq", last_sin, lit_seq);

    // Same load, second word withheld five cycles.
    valid_hi = 0;
    ld_stall[1] = 5;
    do_load(-1);
    chk("t2_literal_chain", chain, 12'hCA5);

    // Readback, immediate accept then with a 10-cycle stall.
    do_rb(0, -1);
    chk("t3_word0", got_rd[0], 8'hA5);
    chk("t3_word1", got_rd[1], 8'h0C);
    do_rb(10, -1);

    // Reset after five shifted bits of a load.
    ld_words[0] = W'($urandom); ld_words[1] = W'($urandom);
    cfg_start = 1'b1; cfg_mode = 1'b0;
    tick();
    cfg_start = 1'b0;
    e0 = en_cnt; cyc = 0;
    while ((en_cnt - e0) < 5 && cyc < 100) begin
      if (cfg_ready) begin
        cfg_valid = 1'b1; cfg_data = W'($urandom);
      end
      cyc++;
      tick();
    end
    chk("rst_mid_bits", en_cnt - e0, 5);
    reset = 1'b1; cfg_valid = 1'b0;
    tick();
    chk_reset("rst_mid");
    reset = 1'b0;
    tick();
    ld_stall[0] = 0; ld_stall[1] = 0;
    do_load(-1);

    // cfg_start while busy must be ignored.
    ld_words[0] = W'($urandom); ld_words[1] = W'($urandom);
    do_load(4);
    do_rb(0, 3);

    // Randomized loads and readbacks.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NW; k++) begin
        ld_words[k] = W'($urandom);
        ld_stall[k] = int'($urandom_range(0, 3));
      end
      valid_hi = ($urandom % 2) == 1;
      do_load(int'($urandom_range(1, 10)));
      do_rb(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
